prbs8_checker: RTL
==================

Name: prbs8_checker

Overview:
- Receive-side counterpart of the on-chip 8-bit LFSR pattern source.
- Takes the serial stream coming back out of the SISO chain, self-synchronises to the x^8+x^6+x^5+x^4+1 maximal-length sequence (period 255), and reports lock status, per-bit error pulses and a saturating error count.
- Sits beside LFSR8 in the top level, clocked by the selected clock (CLK_OUT) and reset by the resynchronised INT_RESET.

Parameters:
- LOCK_THRESH, 16: consecutive matching bits in HUNT needed to declare lock (range 1..255).
- UNLOCK_ERRS, 4: consecutive mismatching bits in LOCK that force return to HUNT (range 1..15).
- CNT_W, 8: width of ERR_CNT.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  reset, synchronous, active-low.
- EN  in  1  bit strobe; D_IN is consumed only on edges where EN=1.
- D_IN  in  1  received serial bit.
- CLR_CNT  in  1  synchronous clear of ERR_CNT.
- LOCKED  out  1  1 while in LOCK state.
- ERR  out  1  one-cycle pulse per counted mismatch.
- ERR_CNT  out  CNT_W  saturating error count.
- PRED  out  1  predicted bit for the next enabled cycle (debug).

Behaviour:
- Reset: RESET=0 sampled at a CLK edge sets H=8'h00, FILL=0, MCNT=0, ECNT=0, state=HUNT, LOCKED=0, ERR=0, ERR_CNT=0. Reset applies in any state, including mid-lock, and overrides EN and CLR_CNT.
- History H[7:0]: H[k] holds the bit received k+1 enabled cycles ago.
  - Prediction: P = H[7]^H[5]^H[4]^H[3], i.e. b[n]=b[n-8]^b[n-6]^b[n-5]^b[n-4].
  - PRED = P, combinational from H.
  - On EN=1, H shifts: H <= {H[6:0], S}. S is D_IN, except in LOCK with the flywheel option, where S is P.
- EN=0: no state change; ERR=0 on that edge.
- All outputs are registered. The effect of the bit sampled at edge k is visible right after edge k; there are no extra pipeline stages.
- HUNT:
  - While FILL<8, each enabled bit increments FILL with no compare.
  - Once FILL=8 (saturates), each enabled bit is compared against P.
  - MCNT increments on a match and clears to 0 on a mismatch.
  - Zero-lock guard: a match with H=0 and D_IN=0 counts as a mismatch.
  - When MCNT reaches LOCK_THRESH on an edge, the state becomes LOCK and LOCKED=1 from that edge. ECNT=0.
  - In HUNT, ERR stays 0 and ERR_CNT does not change.
- LOCK:
  - On a mismatch: ERR=1 for one cycle, ERR_CNT increments (saturating at all-ones), ECNT increments.
  - On a match: ECNT clears to 0.
  - When ECNT reaches UNLOCK_ERRS, the state becomes HUNT on that same edge: LOCKED=0, MCNT=0, FILL stays 8. That error is still counted.
  - If H would become 8'h00 after a shift, the state goes to HUNT (stuck-at-zero exit).
- CLR_CNT=1: ERR_CNT <= 0 on that edge. Clear wins over a simultaneous increment. ERR still pulses.
- Saturation: ERR_CNT holds at 2^CNT_W-1 and never wraps.

Optional Feature:
- Macro: PRBS8_CHECKER_FLYWHEEL_EN.
- Defined: in LOCK, H is fed with P instead of D_IN. The local generator free-runs, so a single flipped bit counts exactly 1 error.
- Undefined: H is always fed with D_IN (pure self-synchronising). A single flipped bit produces 5 errors, at lags 0, 4, 5, 6 and 8 relative to the flipped bit.
- HUNT behaviour is identical in both builds.

Test Plan:
1. Lock-up: reset, then 24 correct PRBS bits with EN=1 every cycle. Required: LOCKED=1 right after the 24th edge (8 fill + 16 matches), ERR_CNT=0, ERR never asserted.
2. Single bit error: locked, invert one D_IN bit. Required: ERR_CNT=1 with the flywheel macro, 5 without; LOCKED stays 1.
3. Burst error: locked, invert 4 consecutive bits. Required: ERR_CNT=4 and LOCKED=0 right after the 4th inverted bit (both builds). Then 24 further correct bits re-lock.
4. Zero and gapped input:
   - 100 enabled bits of D_IN=0 after reset: LOCKED stays 0.
   - Correct PRBS with EN randomly 0 on ~50% of cycles: same lock point (24th enabled bit) and ERR_CNT=0.
5. Saturation and clear:
   - CNT_W=8, 300 mismatches injected while kept locked (invert every 2nd bit, flywheel build): ERR_CNT=255.
   - CLR_CNT=1 on the same edge as an error: ERR_CNT=0, ERR=1.
6. Mid-operation reset: assert RESET=0 for one edge while locked with ERR_CNT=3. Required: LOCKED=0, ERR_CNT=0, ERR=0 after that edge; 24 correct bits re-lock.

Source files
------------

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the x^8+x^6+x^5+x^4+1 pattern source: hunts for lock, then counts bit errors.
// Build option: define PRBS8_CHECKER_FLYWHEEL_EN to free-run the local generator while locked.
module prbs8_checker #(
  parameter int LOCK_THRESH = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             D_IN,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             PRED
);

  typedef enum logic {HUNT, LOCK} state_e;

  state_e           state_q, state_d;
  logic [7:0]       h_q, h_d;
  logic [3:0]       fill_q, fill_d;
  logic [7:0]       mcnt_q, mcnt_d;
  logic [3:0]       ecnt_q, ecnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pred;
  logic       feed;
  logic       match;
  logic [7:0] h_shift;

  assign pred    = h_q[7] ^ h_q[5] ^ h_q[4] ^ h_q[3];
  assign match   = (D_IN == pred);
  assign h_shift = {h_q[6:0], feed};

`ifdef PRBS8_CHECKER_FLYWHEEL_EN
  // Once locked the history is regenerated locally, so a received error never pollutes it.
  assign feed = (state_q == LOCK) ? pred : D_IN;
`else
  assign feed = D_IN;
`endif

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    mcnt_d  = mcnt_q;
    ecnt_d  = ecnt_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (EN) begin
      h_d = h_shift;
      case (state_q)
        HUNT: begin
          if (fill_q != 4'd8) begin
            fill_d = fill_q + 4'd1;
          end else if (match && !(h_q == 8'h00 && !D_IN)) begin
            // An all-zero history predicts zero forever; never let that count toward lock.
            mcnt_d = mcnt_q + 8'd1;
            if (mcnt_q == 8'(LOCK_THRESH - 1)) begin
              state_d = LOCK;
              ecnt_d  = 4'd0;
            end
          end else begin
            mcnt_d = 8'd0;
          end
        end
        LOCK: begin
          if (!match) begin
            err_d  = 1'b1;
            cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            ecnt_d = ecnt_q + 4'd1;
            if (ecnt_q == 4'(UNLOCK_ERRS - 1)) begin
              state_d = HUNT;
              mcnt_d  = 8'd0;
            end
          end else begin
            ecnt_d = 4'd0;
          end
          if (h_shift == 8'h00) begin
            state_d = HUNT;
            mcnt_d  = 8'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (CLR_CNT) cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= HUNT;
      h_q     <= 8'h00;
      fill_q  <= 4'd0;
      mcnt_q  <= 8'd0;
      ecnt_q  <= 4'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      mcnt_q  <= mcnt_d;
      ecnt_q  <= ecnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LOCKED  = (state_q == LOCK);
  assign ERR     = err_q;
  assign ERR_CNT = cnt_q;
  assign PRED    = pred;

endmodule
